isa_fetch_cache: RTL and testbench
==================================

ISA_FETCH_CACHE -- requirements
Module: isa_fetch_cache

Interface
REQ-001 SHALL have parameters: ISA_WIDTH=30, instruction width; DDR_ADDR_WIDTH=28, DDR address width; PC_WIDTH=16, instruction-index width; LINE_DEPTH=16, instructions per line (power of 2, ≤512).
REQ-002 SHALL have ports:
- mem_clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  core fetch strobe, one cycle per request.
- fetch_pc  in  PC_WIDTH  instruction index to fetch.
- flush  in  1  invalidate line.
- fetch_busy  out  1  high while a request is outstanding.
- instr_valid  out  1  one-cycle pulse with instr_out.
- instr_out  out  ISA_WIDTH  fetched instruction.
- ISA_read_req  out  1  line-fill request to the DDR interface.
- ISA_read_addr  out  DDR_ADDR_WIDTH  fill start address.
- isa_read_len  out  10  fill length in beats.
- instruction_to_cache  in  ISA_WIDTH  registered fill beat from the DDR interface.
- rd_cnt_isa  in  10  fill beat count from the DDR interface.
- ddr_rdy  in  1  DDR preload complete.

Function
REQ-003 SHALL hold one line: LINE_DEPTH x ISA_WIDTH storage, base tag = fetch_pc[PC_WIDTH-1:log2(LINE_DEPTH)], and a valid bit.
REQ-004 SHALL have states IDLE, REQ, FILL, RESP.
REQ-005 SHALL treat a fetch_req in IDLE with valid=1 and matching tag as a hit: instr_valid=1 and instr_out=line[fetch_pc offset] on the next edge; state stays IDLE.
REQ-006 SHALL treat a fetch_req in IDLE that misses as follows: latch fetch_pc, raise fetch_busy, go to REQ.
REQ-007 SHALL, in REQ, drive ISA_read_req=1, ISA_read_addr = {aligned line index, 3'b000} zero-extended (8 address units per instruction), and isa_read_len=LINE_DEPTH; REQ waits while ddr_rdy=0.
REQ-008 SHALL drop ISA_read_req and enter FILL on the first cycle rd_cnt_isa is nonzero.
REQ-009 SHALL write instruction_to_cache to line[rd_cnt_isa-1] in any REQ/FILL cycle where rd_cnt_isa differs from its value registered one cycle earlier and is nonzero (the beat lags its count increment by one cycle).
REQ-010 SHALL, when the write with rd_cnt_isa==LINE_DEPTH occurs, set valid=1, load the tag, and go to RESP.
REQ-011 SHALL, in RESP, pulse instr_valid with line[latched offset], clear fetch_busy, and return to IDLE; miss latency is therefore fill time + 1 cycle.
REQ-012 SHALL ignore fetch_req while fetch_busy=1; the core holds its request.
REQ-013 SHALL clear valid on the next edge when flush is asserted in IDLE; a flush during REQ/FILL/RESP is recorded and applied on RESP exit, after the pending response is delivered.
REQ-014 SHALL give flush priority over fetch_req in the same IDLE cycle; the fetch is dropped.
REQ-015 SHALL ignore fill beats with rd_cnt_isa > LINE_DEPTH.
REQ-016 SHALL keep instr_out at its previous value when instr_valid=0.

Reset
REQ-017 SHALL on rst_n=0 asynchronously set state=IDLE, valid=0, tag=0, pending flush=0, fetch_busy=0, instr_valid=0, instr_out=0, ISA_read_req=0, ISA_read_addr=0, isa_read_len=0, and any counters to 0; line storage is not reset.
REQ-018 SHALL abandon an in-progress fill when reset is asserted mid-fill; the first post-reset fetch misses.

Configuration
REQ-019 SHALL, with ISA_FETCH_CACHE_PERF_EN defined, add outputs hit_cnt[15:0] and miss_cnt[15:0]: each increments once per accepted hit or miss, saturates at 16'hFFFF, and resets to 0.
REQ-020 SHALL, without ISA_FETCH_CACHE_PERF_EN, omit those ports and counters entirely; all other behaviour is identical.

Structure
REQ-021 SHALL place the state encoding (IDLE=0, REQ=1, FILL=2, RESP=3) and the 8-unit address-stride constant in shared package isa_cache_pkg.
REQ-022 SHALL implement storage in one sub-module, isa_line_ram: 1 write port, 1 asynchronous read port, LINE_DEPTH deep.

Verification
REQ-023 Cold miss: after reset with ddr_rdy=1, fetch_pc=0x0013 -> ISA_read_addr=0x0000080, isa_read_len=16; after 16 beats, instr_out = beat 3 and instr_valid pulses once.
REQ-024 Hit: after REQ-023, fetch_pc=0x001F -> instr_valid on the next edge with beat 15, and ISA_read_req stays 0.
REQ-025 ddr_rdy low: a miss with ddr_rdy=0 for 50 cycles -> ISA_read_req held high and fetch_busy=1 throughout; the fill proceeds once ddr_rdy=1.
REQ-026 Flush mid-fill: flush at beat 5 -> the response is still delivered, valid=0 afterwards, and a refetch of 0x0013 misses.
REQ-027 Reset mid-fill: rst_n low at beat 8 -> all outputs 0 immediately; the next fetch of 0x0013 issues a new fill.
REQ-028 PERF build: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3; with hit_cnt forced to 0xFFFF, one more hit leaves it at 0xFFFF.

Source files
------------

// File: rtl/isa_cache_pkg.sv
// Shared constants for the single-line instruction fetch cache.
// Holds the FSM state encoding and the DDR address stride per instruction.
package isa_cache_pkg;

  // FSM state encoding shared by the cache and anything that probes it
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  // Each instruction occupies 8 DDR address units, so an instruction index
  // becomes a DDR address by shifting left by 3
  localparam int unsigned ADDR_STRIDE = 8;
  localparam int unsigned ADDR_SHIFT  = 3;

endpackage

// File: rtl/isa_line_ram.sv
// Line storage for the fetch cache: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module isa_line_ram #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             mem_clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture a fill beat into its slot
  always_ff @(posedge mem_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/isa_fetch_cache.sv
// Single-line instruction fetch cache between the core and the DDR interface.
// A hit answers on the next edge; a miss fills the whole line from DDR and
// then answers from the freshly written line.
// Optional build macro ISA_FETCH_CACHE_PERF_EN adds saturating hit/miss counters.
module isa_fetch_cache
  import isa_cache_pkg::*;
#(
  parameter int ISA_WIDTH      = 30,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int PC_WIDTH       = 16,
  parameter int LINE_DEPTH     = 16
) (
  input  logic                      mem_clk,
  input  logic                      rst_n,
  input  logic                      fetch_req,
  input  logic [PC_WIDTH-1:0]       fetch_pc,
  input  logic                      flush,
  output logic                      fetch_busy,
  output logic                      instr_valid,
  output logic [ISA_WIDTH-1:0]      instr_out,
  output logic                      ISA_read_req,
  output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
  output logic [9:0]                isa_read_len,
  input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
  input  logic [9:0]                rd_cnt_isa,
  input  logic                      ddr_rdy
`ifdef ISA_FETCH_CACHE_PERF_EN
  ,
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_DEPTH);
  localparam int TAG_W = PC_WIDTH - OFF_W;
  localparam logic [9:0] LEN = 10'(LINE_DEPTH);

  logic [1:0]           state;
  logic                 valid;
  logic [TAG_W-1:0]     tag;
  logic                 flush_pend;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [9:0]           rd_cnt_q;

  logic                 accept;
  logic                 hit;
  logic                 beat_wr;
  logic                 last_beat;
  logic [9:0]           beat_idx;
  logic [OFF_W-1:0]     wr_addr;
  logic [OFF_W-1:0]     rd_addr;
  logic [ISA_WIDTH-1:0] rd_data;

  // Decode lookups and fill beats; a beat counts only when the DDR count moves
  always_comb begin
    accept    = (state == IDLE) && fetch_req && !flush;
    hit       = accept && valid && (fetch_pc[PC_WIDTH-1:OFF_W] == tag);
    beat_wr   = ((state == REQ) || (state == FILL)) && (rd_cnt_isa != rd_cnt_q) &&
                (rd_cnt_isa != 10'd0) && (rd_cnt_isa <= LEN);
    last_beat = beat_wr && (rd_cnt_isa == LEN);
    beat_idx  = rd_cnt_isa - 10'd1;
    wr_addr   = beat_idx[OFF_W-1:0];
    rd_addr   = (state == RESP) ? pc_q[OFF_W-1:0] : fetch_pc[OFF_W-1:0];
  end

  isa_line_ram #(
    .WIDTH (ISA_WIDTH),
    .DEPTH (LINE_DEPTH)
  ) u_line_ram (
    .mem_clk (mem_clk),
    .we      (beat_wr),
    .waddr   (wr_addr),
    .wdata   (instruction_to_cache),
    .raddr   (rd_addr),
    .rdata   (rd_data)
  );

  // Remember the previous DDR beat count so repeated counts are not rewritten
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) rd_cnt_q <= 10'd0;
    else        rd_cnt_q <= rd_cnt_isa;
  end

  // Lookup / fill / respond sequencing
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= 1'b0;
      tag           <= '0;
      flush_pend    <= 1'b0;
      pc_q          <= '0;
      fetch_busy    <= 1'b0;
      instr_valid   <= 1'b0;
      instr_out     <= '0;
      ISA_read_req  <= 1'b0;
      ISA_read_addr <= '0;
      isa_read_len  <= 10'd0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            valid <= 1'b0;
          end else if (hit) begin
            instr_valid <= 1'b1;
            instr_out   <= rd_data;
          end else if (accept) begin
            pc_q          <= fetch_pc;
            fetch_busy    <= 1'b1;
            ISA_read_req  <= 1'b1;
            ISA_read_addr <= DDR_ADDR_WIDTH'({fetch_pc[PC_WIDTH-1:OFF_W],
                                             {OFF_W{1'b0}}, {ADDR_SHIFT{1'b0}}});
            isa_read_len  <= LEN;
            state         <= REQ;
          end
        end
        REQ, FILL: begin
          if (flush) flush_pend <= 1'b1;
          if ((state == REQ) && ddr_rdy && (rd_cnt_isa != 10'd0)) begin
            ISA_read_req <= 1'b0;
            state        <= FILL;
          end
          if (last_beat) begin
            ISA_read_req <= 1'b0;
            valid        <= 1'b1;
            tag          <= pc_q[PC_WIDTH-1:OFF_W];
            state        <= RESP;
          end
        end
        RESP: begin
          instr_valid <= 1'b1;
          instr_out   <= rd_data;
          fetch_busy  <= 1'b0;
          state       <= IDLE;
          if (flush_pend || flush) begin
            valid      <= 1'b0;
            flush_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ISA_FETCH_CACHE_PERF_EN
  // Saturating counts of accepted hits and misses
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 16'd0;
      miss_cnt <= 16'd0;
    end else begin
      if (hit && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
      if (accept && !hit && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_isa_fetch_cache.sv
// Directed bench for isa_fetch_cache: cold miss, table of hits, flush and
// reset corner cases, and the optional counters when ISA_FETCH_CACHE_PERF_EN is set.
module tb_isa_fetch_cache;

  typedef struct {
    logic [15:0] pc;
    logic [29:0] data;
  } hit_vec_t;

  localparam logic [29:0] GARBAGE = 30'h15555555;

  logic        mem_clk;
  logic        rst_n;
  logic        fetch_req;
  logic [15:0] fetch_pc;
  logic        flush;
  logic        fetch_busy;
  logic        instr_valid;
  logic [29:0] instr_out;
  logic        ISA_read_req;
  logic [27:0] ISA_read_addr;
  logic [9:0]  isa_read_len;
  logic [29:0] instruction_to_cache;
  logic [9:0]  rd_cnt_isa;
  logic        ddr_rdy;
`ifdef ISA_FETCH_CACHE_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int total = 0;
  int bad = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  hit_vec_t vecs [5];

  isa_fetch_cache dut (
    .mem_clk              (mem_clk),
    .rst_n                (rst_n),
    .fetch_req            (fetch_req),
    .fetch_pc             (fetch_pc),
    .flush                (flush),
    .fetch_busy           (fetch_busy),
    .instr_valid          (instr_valid),
    .instr_out            (instr_out),
    .ISA_read_req         (ISA_read_req),
    .ISA_read_addr        (ISA_read_addr),
    .isa_read_len         (isa_read_len),
    .instruction_to_cache (instruction_to_cache),
    .rd_cnt_isa           (rd_cnt_isa),
    .ddr_rdy              (ddr_rdy)
`ifdef ISA_FETCH_CACHE_PERF_EN
    ,
    .hit_cnt              (hit_cnt),
    .miss_cnt             (miss_cnt)
`endif
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Distinct data per fill (seed) and beat position
  function automatic logic [29:0] beat_val(input int seed, input int k);
    return 30'((seed << 20) | (k * 4099 + 7));
  endfunction

  // Drive one cycle of core-side inputs, then settle just after the edge
  task automatic applyStimulus(input logic req, input logic [15:0] pc, input logic fl);
    fetch_req = req;
    fetch_pc  = pc;
    flush     = fl;
    @(posedge mem_clk);
    #1;
    fetch_req = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tagname);
    checkOutput({tagname, "_busy"}, 32'(fetch_busy), 32'd0);
    checkOutput({tagname, "_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tagname, "_out"}, 32'(instr_out), 32'd0);
    checkOutput({tagname, "_req"}, 32'(ISA_read_req), 32'd0);
    checkOutput({tagname, "_addr"}, 32'(ISA_read_addr), 32'd0);
    checkOutput({tagname, "_len"}, 32'(isa_read_len), 32'd0);
  endtask

  // A hit: answer on the next edge, no DDR request, pulse lasts one cycle
  task automatic run_hit(input logic [15:0] pc, input logic [29:0] exp_data);
    applyStimulus(1'b1, pc, 1'b0);
    exp_hits++;
    checkOutput("hit_valid", 32'(instr_valid), 32'd1);
    checkOutput("hit_data", 32'(instr_out), 32'(exp_data));
    checkOutput("hit_no_req", 32'(ISA_read_req), 32'd0);
    checkOutput("hit_not_busy", 32'(fetch_busy), 32'd0);
    applyStimulus(1'b0, pc, 1'b0);
    checkOutput("hit_pulse_once", 32'(instr_valid), 32'd0);
    checkOutput("hit_hold", 32'(instr_out), 32'(exp_data));
  endtask

  // A miss: request, optional ddr_rdy stall, 16 beats, then the response.
  // glitch repeats one count with junk data and injects an out-of-range count
  // that aliases onto the requested slot; neither may corrupt it.
  task automatic run_miss(input logic [15:0] pc, input int seed, input int rdy_delay,
                          input int flush_beat, input bit glitch);
    int off;
    logic [29:0] exp_data;
    off = int'(pc[3:0]);
    exp_data = beat_val(seed, off);
    ddr_rdy = (rdy_delay == 0);
    rd_cnt_isa = 10'd0;
    applyStimulus(1'b1, pc, 1'b0);
    exp_misses++;
    checkOutput("miss_req", 32'(ISA_read_req), 32'd1);
    checkOutput("miss_busy", 32'(fetch_busy), 32'd1);
    checkOutput("miss_addr", 32'(ISA_read_addr), {13'd0, pc[15:4], 7'd0});
    checkOutput("miss_len", 32'(isa_read_len), 32'd16);
    checkOutput("miss_no_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < rdy_delay; i++) begin
      applyStimulus(1'b0, pc, 1'b0);
      checkOutput("wait_req", 32'(ISA_read_req), 32'd1);
      checkOutput("wait_busy", 32'(fetch_busy), 32'd1);
    end
    ddr_rdy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      rd_cnt_isa = 10'(k);
      instruction_to_cache = beat_val(seed, k - 1);
      applyStimulus(1'b0, pc, (k == flush_beat));
      checkOutput("fill_req_low", 32'(ISA_read_req), 32'd0);
      checkOutput("fill_busy", 32'(fetch_busy), 32'd1);
      if (glitch && (k == off + 1) && (k < 16)) begin
        instruction_to_cache = GARBAGE;
        applyStimulus(1'b0, pc, 1'b0);
        rd_cnt_isa = 10'(off + 17);
        applyStimulus(1'b0, pc, 1'b0);
      end
    end
    checkOutput("resp_pending", 32'(instr_valid), 32'd0);
    rd_cnt_isa = 10'd0;
    applyStimulus(1'b0, pc, 1'b0);
    checkOutput("resp_valid", 32'(instr_valid), 32'd1);
    checkOutput("resp_data", 32'(instr_out), 32'(exp_data));
    checkOutput("resp_busy_clr", 32'(fetch_busy), 32'd0);
    applyStimulus(1'b0, pc, 1'b0);
    checkOutput("resp_pulse_once", 32'(instr_valid), 32'd0);
    checkOutput("resp_hold", 32'(instr_out), 32'(exp_data));
  endtask

  // Overall run time bound
  initial begin
    #300000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Main directed sequence
  initial begin
    vecs[0] = '{pc: 16'h001F, data: beat_val(1, 15)};
    vecs[1] = '{pc: 16'h0010, data: beat_val(1, 0)};
    vecs[2] = '{pc: 16'h0015, data: beat_val(1, 5)};
    vecs[3] = '{pc: 16'h001A, data: beat_val(1, 10)};
    vecs[4] = '{pc: 16'h0013, data: beat_val(1, 3)};

    rst_n = 1'b0;
    fetch_req = 1'b0;
    fetch_pc = 16'd0;
    flush = 1'b0;
    instruction_to_cache = '0;
    rd_cnt_isa = 10'd0;
    ddr_rdy = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd0, 1'b0);
    check_all_zero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0);

    // Cold miss, then hits across the line
    run_miss(16'h0013, 1, 0, 0, 1'b0);
    foreach (vecs[i]) run_hit(vecs[i].pc, vecs[i].data);

    // Flush beats a same-cycle fetch, and the line is gone afterwards
    applyStimulus(1'b1, 16'h0015, 1'b1);
    checkOutput("flush_prio_valid", 32'(instr_valid), 32'd0);
    checkOutput("flush_prio_busy", 32'(fetch_busy), 32'd0);
    checkOutput("flush_prio_req", 32'(ISA_read_req), 32'd0);
    run_miss(16'h0015, 2, 50, 0, 1'b1);

    // Different line misses; flush during the fill still delivers, then invalidates
    run_miss(16'h0033, 3, 0, 5, 1'b0);
    run_miss(16'h0033, 4, 0, 0, 1'b0);

`ifdef ISA_FETCH_CACHE_PERF_EN
    checkOutput("perf_miss", 32'(miss_cnt), 32'(exp_misses));
    checkOutput("perf_hit", 32'(hit_cnt), 32'(exp_hits));
    force dut.hit_cnt = 16'hFFFF;
    #1;
    release dut.hit_cnt;
    run_hit(16'h0033, beat_val(4, 3));
    checkOutput("perf_sat", 32'(hit_cnt), 32'h0000FFFF);
`endif

    // Reset in the middle of a fill
    applyStimulus(1'b1, 16'h0023, 1'b0);
    checkOutput("rst_fill_req", 32'(ISA_read_req), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      rd_cnt_isa = 10'(k);
      instruction_to_cache = beat_val(5, k - 1);
      applyStimulus(1'b0, 16'h0023, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midfill_reset");
`ifdef ISA_FETCH_CACHE_PERF_EN
    checkOutput("perf_rst_hit", 32'(hit_cnt), 32'd0);
    checkOutput("perf_rst_miss", 32'(miss_cnt), 32'd0);
`endif
    rd_cnt_isa = 10'd0;
    applyStimulus(1'b0, 16'd0, 1'b0);
    applyStimulus(1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd0, 1'b0);
    // 0x33 was cached before the reset, so a miss here proves valid was cleared
    run_miss(16'h0033, 6, 0, 0, 1'b0);
    run_hit(16'h0038, beat_val(6, 8));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
